ysyx_22050518_wb_arbiter: RTL and testbench

YSYX_22050518_WB_ARBITER -- requirements
Module: ysyx_22050518_wb_arbiter

---
 rtl/ysyx_22050518_wb_arbiter_if.sv | 34 +++
 rtl/ysyx_22050518_wb_arbiter.sv | 94 +++++++++
 tb/tb_ysyx_22050518_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050518_wb_arbiter_if.sv
// Writeback arbiter bus: requester-side write requests, register-file write port,
// scoreboard set/flush controls and hazard-query signals.
interface ysyx_22050518_wb_arbiter_if #(
    parameter int XLEN = 64,
    parameter int NREQ = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_rd_addr;
    logic [XLEN*NREQ-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wb_stall;
    logic                 rf_write_en;
    logic [4:0]           rf_rd_addr;
    logic [XLEN-1:0]      rf_rd;
    logic                 sb_set_en;
    logic [4:0]           sb_set_addr;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 flush;

    modport master (
        output req_valid, req_rd_addr, req_data, wb_stall,
        output sb_set_en, sb_set_addr, rs1_addr, rs2_addr, flush,
        input  req_ready, rf_write_en, rf_rd_addr, rf_rd, rs1_busy, rs2_busy
    );

    modport slave (
        input  req_valid, req_rd_addr, req_data, wb_stall,
        input  sb_set_en, sb_set_addr, rs1_addr, rs2_addr, flush,
        output req_ready, rf_write_en, rf_rd_addr, rf_rd, rs1_busy, rs2_busy
    );
endinterface

// File: rtl/ysyx_22050518_wb_arbiter.sv
// Round-robin writeback arbiter with a registered register-file write port and a
// 32-entry pending-register scoreboard for hazard detection.
module ysyx_22050518_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NREQ = 3
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_22050518_wb_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [31:0]     pending_q, pending_d;
    logic            rf_we_q;
    logic [4:0]      rf_addr_q;
    logic [XLEN-1:0] rf_data_q;

    logic            grant_any;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    int              cand_int;
    logic [4:0]      win_addr;
    logic [XLEN-1:0] win_data;

    // Search starts at the pointer and wraps; the first valid requester wins.
    always_comb begin
        // NOTE: every combinational variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        grant_any = 1'b0;
        win_idx   = '0;
        cand_int  = 0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_int = int'(ptr_q) + k;
            if (cand_int >= NREQ) cand_int = cand_int - NREQ;
            cand = PW'(cand_int);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                win_idx   = cand;
            end
        end
        if (bus.wb_stall || !rst_n) grant_any = 1'b0;
    end

    assign win_addr = bus.req_rd_addr[5*int'(win_idx) +: 5];
    assign win_data = bus.req_data[XLEN*int'(win_idx) +: XLEN];

    always_comb begin
        bus.req_ready = '0;
        if (grant_any) bus.req_ready[win_idx] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    end

    // Set beats a same-edge clear; flush beats everything; x0 is never pending.
    always_comb begin
        pending_d = pending_q;
        if (grant_any) pending_d[win_addr] = 1'b0;
        if (bus.sb_set_en) pending_d[bus.sb_set_addr] = 1'b1;
        if (bus.flush) pending_d = '0;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the scoreboard is ordinary flops rather than a RAM, so it is cleared by
        // reset together with the rest of the state.
        if (!rst_n) begin
            ptr_q     <= '0;
            pending_q <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            rf_we_q   <= grant_any && (win_addr != 5'd0);
            if (grant_any && (win_addr != 5'd0)) begin
                rf_addr_q <= win_addr;
                rf_data_q <= win_data;
            end
        end
    end

    assign bus.rf_write_en = rf_we_q;
    assign bus.rf_rd_addr  = rf_addr_q;
    assign bus.rf_rd       = rf_data_q;
    assign bus.rs1_busy    = pending_q[bus.rs1_addr];
    assign bus.rs2_busy    = pending_q[bus.rs2_addr];
endmodule

// File: tb/tb_ysyx_22050518_wb_arbiter.sv
// Directed bench: stimulus pushes expected register-file writes into a queue and a
// negedge monitor pops and compares them against the write port.
module tb_ysyx_22050518_wb_arbiter;
    localparam int XLEN = 64;
    localparam int NREQ = 3;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22050518_wb_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

    ysyx_22050518_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
        bus.req_rd_addr[5*i +: 5]  = a;
        bus.req_data[XLEN*i +: XLEN] = d;
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [63:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.rf_write_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("spurious_rf_write_en", 64'(bus.rf_write_en), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_addr", 64'(bus.rf_rd_addr), 64'(mon_e.addr));
                check("wb_data", bus.rf_rd, mon_e.data);
                check("wb_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            check("missing_rf_write_en", 64'(bus.rf_write_en), 64'd1);
        end
    end

    initial begin
        bus.req_valid   = '0;
        bus.req_rd_addr = '0;
        bus.req_data    = '0;
        bus.wb_stall    = 1'b0;
        bus.sb_set_en   = 1'b0;
        bus.sb_set_addr = '0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
        bus.flush       = 1'b0;

        // Reset: ready stays low even with every request valid.
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = 3'b111;
        set_req(0, 5'd5, 64'h1111_0000_0000_0005);
        set_req(1, 5'd6, 64'h2222_0000_0000_0006);
        set_req(2, 5'd7, 64'h3333_0000_0000_0007);
        bus.rs1_addr = 5'd5;
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_wr_en", 64'(bus.rf_write_en), 64'd0);
        check("rst_rd_addr", 64'(bus.rf_rd_addr), 64'd0);
        check("rst_rd", bus.rf_rd, 64'd0);
        check("rst_busy", 64'(bus.rs1_busy), 64'd0);

        // Round robin with all three valid: EXU, LSU, CSR, EXU.
        tick();
        rst_n = 1'b1;
        #1;
        check("rr_grant0", 64'(bus.req_ready), 64'b001);
        push_wr(5'd5, 64'h1111_0000_0000_0005);
        tick(); #1;
        check("rr_grant1", 64'(bus.req_ready), 64'b010);
        push_wr(5'd6, 64'h2222_0000_0000_0006);
        tick(); #1;
        check("rr_grant2", 64'(bus.req_ready), 64'b100);
        push_wr(5'd7, 64'h3333_0000_0000_0007);
        tick(); #1;
        check("rr_grant3", 64'(bus.req_ready), 64'b001);
        push_wr(5'd5, 64'h1111_0000_0000_0005);
        tick();
        bus.req_valid = '0;

        // Scoreboard set of x9, no same-cycle bypass, x0 never pending, cleared by LSU write.
        bus.sb_set_en   = 1'b1;
        bus.sb_set_addr = 5'd9;
        bus.rs1_addr    = 5'd9;
        #1;
        check("busy_no_bypass", 64'(bus.rs1_busy), 64'd0);
        tick();
        bus.sb_set_addr = 5'd0;
        bus.rs2_addr    = 5'd0;
        #1;
        check("busy_x9_set", 64'(bus.rs1_busy), 64'd1);
        tick();
        bus.sb_set_en = 1'b0;
        bus.req_valid = 3'b010;
        set_req(1, 5'd9, 64'hABCD_1234_5678_0009);
        #1;
        check("busy_x0_zero", 64'(bus.rs2_busy), 64'd0);
        check("lsu_grant", 64'(bus.req_ready), 64'b010);
        check("busy_x9_in_grant", 64'(bus.rs1_busy), 64'd1);
        push_wr(5'd9, 64'hABCD_1234_5678_0009);
        tick();
        bus.req_valid = '0;
        #1;
        check("busy_x9_cleared", 64'(bus.rs1_busy), 64'd0);

        // Same-edge set and clear of x12: set wins; a later write clears it.
        tick();
        bus.req_valid   = 3'b100;
        set_req(2, 5'd12, 64'h0000_0000_C0DE_000C);
        bus.sb_set_en   = 1'b1;
        bus.sb_set_addr = 5'd12;
        #1;
        check("csr_grant_x12", 64'(bus.req_ready), 64'b100);
        push_wr(5'd12, 64'h0000_0000_C0DE_000C);
        tick();
        bus.sb_set_en = 1'b0;
        bus.req_valid = '0;
        bus.rs2_addr  = 5'd12;
        #1;
        check("busy_x12_set_wins", 64'(bus.rs2_busy), 64'd1);
        tick();
        bus.req_valid = 3'b001;
        set_req(0, 5'd12, 64'h0000_0000_BEEF_000C);
        #1;
        check("exu_grant_x12", 64'(bus.req_ready), 64'b001);
        push_wr(5'd12, 64'h0000_0000_BEEF_000C);
        tick();
        bus.req_valid = '0;
        #1;
        check("busy_x12_cleared", 64'(bus.rs2_busy), 64'd0);

        // Bring ptr back to 0, then an x0 writeback that consumes its grant silently.
        tick();
        bus.req_valid = 3'b100;
        set_req(2, 5'd13, 64'h0000_0000_0000_D00D);
        #1;
        check("csr_grant_x13", 64'(bus.req_ready), 64'b100);
        push_wr(5'd13, 64'h0000_0000_0000_D00D);
        tick();
        bus.req_valid = 3'b001;
        set_req(0, 5'd0, 64'h0000_0000_0000_DEAD);
        #1;
        check("exu_grant_x0", 64'(bus.req_ready), 64'b001);

        // Stall for three cycles with everything valid, then the grant goes to ptr=1.
        tick();
        bus.req_valid = 3'b111;
        set_req(0, 5'd5, 64'hA0A0_A0A0_0000_0005);
        set_req(1, 5'd6, 64'hA1A1_A1A1_0000_0006);
        set_req(2, 5'd7, 64'hA2A2_A2A2_0000_0007);
        bus.wb_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_no_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.wb_stall = 1'b0;
        #1;
        check("stall_release_grant", 64'(bus.req_ready), 64'b010);
        push_wr(5'd6, 64'hA1A1_A1A1_0000_0006);
        tick();
        bus.req_valid = '0;

        // Set x3 and x4, then flush together with a set of x5.
        bus.sb_set_en   = 1'b1;
        bus.sb_set_addr = 5'd3;
        tick();
        bus.sb_set_addr = 5'd4;
        bus.rs1_addr    = 5'd3;
        #1;
        check("busy_x3_set", 64'(bus.rs1_busy), 64'd1);
        tick();
        bus.sb_set_addr = 5'd5;
        bus.flush       = 1'b1;
        bus.rs2_addr    = 5'd4;
        #1;
        check("busy_x4_set", 64'(bus.rs2_busy), 64'd1);
        tick();
        bus.sb_set_en = 1'b0;
        bus.flush     = 1'b0;
        #1;
        check("flush_x3", 64'(bus.rs1_busy), 64'd0);
        check("flush_x4", 64'(bus.rs2_busy), 64'd0);
        tick();
        bus.rs1_addr = 5'd5;
        #1;
        check("flush_beats_set_x5", 64'(bus.rs1_busy), 64'd0);

        // Flush kept ptr at 2; reset asserted mid-grant discards the write.
        tick();
        bus.req_valid = 3'b111;
        #1;
        check("ptr_after_flush", 64'(bus.req_ready), 64'b100);
        #1;
        rst_n = 1'b0;
        #1;
        check("midgrant_rst_ready", 64'(bus.req_ready), 64'd0);
        check("midgrant_rst_wr_en", 64'(bus.rf_write_en), 64'd0);
        check("midgrant_rst_rd_addr", 64'(bus.rf_rd_addr), 64'd0);
        check("midgrant_rst_rd", bus.rf_rd, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", 64'(bus.req_ready), 64'b001);
        push_wr(5'd5, 64'hA0A0_A0A0_0000_0005);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
